// File: rtl/reg_access_ctrl.sv
// Byte-framed register access controller: AA/BB command, address, data bytes in;
// register write/read strobes out and two-byte read responses to a transmitter.
module reg_access_ctrl #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RD_TIMEOUT    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic [WIDTH-1:0]         WrData,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic                     WrEn,
    output logic                     RdEn,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     RdData_Valid,
    output logic [7:0]               TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_Busy,
    output logic                     Err
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] CMD_ADDR = 4'd1;
    localparam logic [3:0] DATA_LO  = 4'd2;
    localparam logic [3:0] DATA_HI  = 4'd3;
    localparam logic [3:0] WRITE    = 4'd4;
    localparam logic [3:0] READ     = 4'd5;
    localparam logic [3:0] WAIT_RD  = 4'd6;
    localparam logic [3:0] TX_LO    = 4'd7;
    localparam logic [3:0] TX_HI    = 4'd8;

    localparam int         TW      = $clog2(RD_TIMEOUT + 1);
    localparam logic [8:0] DEPTH_B = 9'(DEPTH);

    logic [3:0]       state;
    logic             is_wr;
    logic             addr_ok;
    logic [WIDTH-1:0] rd_cap;
    logic [TW-1:0]    to_cnt;
    logic             addr_in_range;

    // The whole received byte is range-checked, not just the bits kept in Address.
    assign addr_in_range = {1'b0, RX_P_DATA} < DEPTH_B;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            is_wr     <= 1'b0;
            addr_ok   <= 1'b0;
            rd_cap    <= '0;
            to_cnt    <= '0;
            WrData    <= '0;
            Address   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Err       <= 1'b0;
        end else begin
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            TX_D_VLD <= 1'b0;
            Err      <= 1'b0;
            case (state)
                IDLE: if (RX_D_VLD) begin
                    if (RX_P_DATA == 8'hAA) begin
                        is_wr <= 1'b1;
                        state <= CMD_ADDR;
                    end else if (RX_P_DATA == 8'hBB) begin
                        is_wr <= 1'b0;
                        state <= CMD_ADDR;
                    end else begin
                        Err <= 1'b1;
                    end
                end
                CMD_ADDR: if (RX_D_VLD) begin
                    Address <= RX_P_DATA[ADDRESS_WIDTH-1:0];
                    addr_ok <= addr_in_range;
                    if (is_wr) begin
                        state <= DATA_LO;
                    end else begin
                        RdEn  <= addr_in_range;
                        Err   <= !addr_in_range;
                        state <= READ;
                    end
                end
                DATA_LO: if (RX_D_VLD) begin
                    WrData[7:0] <= RX_P_DATA;
                    state       <= DATA_HI;
                end
                DATA_HI: if (RX_D_VLD) begin
                    WrData[15:8] <= RX_P_DATA;
                    WrEn         <= addr_ok;
                    Err          <= !addr_ok;
                    state        <= WRITE;
                end
                WRITE: state <= IDLE;
                READ: begin
                    to_cnt <= TW'(1);
                    state  <= addr_ok ? WAIT_RD : IDLE;
                end
                // to_cnt counts cycles since RdEn, so Err lands RD_TIMEOUT cycles after it.
                WAIT_RD: begin
                    if (RdData_Valid) begin
                        rd_cap <= RdData;
                        state  <= TX_LO;
                    end else if (to_cnt >= TW'(RD_TIMEOUT - 1)) begin
                        Err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                TX_LO: if (!TX_Busy) begin
                    TX_P_DATA <= rd_cap[7:0];
                    TX_D_VLD  <= 1'b1;
                    state     <= TX_HI;
                end
                // TX_Busy only rises the cycle after the strobe, so skip the strobe cycle.
                TX_HI: if (!TX_Busy && !TX_D_VLD) begin
                    TX_P_DATA <= rd_cap[15:8];
                    TX_D_VLD  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboarded bench for reg_access_ctrl: frame-level reference model, register
// file and transmitter responders, and a monitor that pops one expectation per output pulse.
module tb_reg_access_ctrl;
    localparam int WIDTH = 16, DEPTH = 8, AW = 4, RD_TIMEOUT = 8;
    localparam int K_WR = 0, K_RD = 1, K_TX = 2, K_ERR = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic [7:0]       RX_P_DATA;
    logic             RX_D_VLD;
    logic [WIDTH-1:0] WrData;
    logic [AW-1:0]    Address;
    logic             WrEn, RdEn;
    logic [WIDTH-1:0] RdData;
    logic             RdData_Valid;
    logic [7:0]       TX_P_DATA;
    logic             TX_D_VLD;
    logic             TX_Busy;
    logic             Err;

    reg_access_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .Err(Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          lat;
        bit          from_rden;
    } exp_t;

    exp_t        sb[$];
    int          total = 0, bad = 0;
    int          cyc = 0, last_rx = 0, last_rden = 0;
    bit          prev_busy = 1'b0;
    bit          withhold = 1'b0;
    int          rd_delay = 2;
    logic [15:0] mem[16];
    logic [15:0] model[DEPTH];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic exp_t mk(int k, logic [31:0] d, int lat, bit fr);
        exp_t e;
        e.kind = k; e.data = d; e.lat = lat; e.from_rden = fr;
        return e;
    endfunction

    task automatic check_evt(input int k, input logic [31:0] d);
        exp_t e;
        int   r;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_evt: got kind=%0d data=%h, expected no event", k, d);
            return;
        end
        e = sb.pop_front();
        if (e.kind != k || e.data != d) begin
            bad++;
            $display("FAIL evt: got kind=%0d data=%h, expected kind=%0d data=%h", k, d, e.kind, e.data);
        end else if (e.lat >= 0) begin
            r = e.from_rden ? last_rden : last_rx;
            if (cyc - r != e.lat) begin
                bad++;
                $display("FAIL latency kind=%0d: got %0d cycles, expected %0d", k, cyc - r, e.lat);
            end
        end
    endtask

    // Monitor and external register file.
    always @(negedge CLK) begin
        if (RST !== 1'b1) begin
            if (WrEn === 1'b1 && RdEn === 1'b1) begin
                total++; bad++;
                $display("FAIL wr_rd_overlap: got WrEn=1 RdEn=1, expected at most one");
            end
            if (WrEn === 1'b1) begin
                check_evt(K_WR, {12'b0, Address, WrData});
                mem[Address] = WrData;
            end
            if (RdEn === 1'b1) begin
                check_evt(K_RD, {28'b0, Address});
                last_rden = cyc;
            end
            if (TX_D_VLD === 1'b1) begin
                total++;
                if (prev_busy) begin
                    bad++;
                    $display("FAIL tx_while_busy: got TX_D_VLD after busy cycle, expected wait");
                end
                check_evt(K_TX, {24'b0, TX_P_DATA});
            end
            if (Err === 1'b1) check_evt(K_ERR, 32'h0);
        end
        prev_busy = TX_Busy;
    end

    // Register file read responder: RdData_Valid rd_delay cycles after RdEn.
    always begin : rd_resp
        int         d;
        logic [3:0] ra;
        @(negedge CLK);
        if (RdEn === 1'b1 && RST !== 1'b1 && !withhold) begin
            d  = rd_delay;
            ra = Address;
            @(posedge CLK); #1;
            repeat (d - 1) begin @(posedge CLK); #1; end
            RdData       = mem[ra];
            RdData_Valid = 1'b1;
            @(posedge CLK); #1;
            RdData_Valid = 1'b0;
        end
    end

    // Transmitter model: busy for 10 cycles starting the cycle after each strobe.
    always begin : tx_model
        @(negedge CLK);
        if (TX_D_VLD === 1'b1 && RST !== 1'b1) begin
            @(posedge CLK); #1;
            TX_Busy = 1'b1;
            repeat (10) @(posedge CLK);
            #1;
            TX_Busy = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        last_rx   = cyc;
        @(posedge CLK); #1;
        RX_D_VLD = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge CLK); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout: got %0d pending events, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string nm);
        logic [31:0] v;
        v = {WrData, Address, WrEn, RdEn, TX_P_DATA, TX_D_VLD, Err};
        total++;
        if (v !== 32'h0) begin
            bad++;
            $display("FAIL %s: got outputs=%h, expected 0", nm, v);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check_zero("reset_state");
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_zero("after_reset");
        @(posedge CLK); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] lo, input logic [7:0] hi, input int gap);
        send_byte(8'hAA, gap);
        send_byte(a, gap);
        send_byte(lo, gap);
        if (int'(a) < DEPTH) begin
            sb.push_back(mk(K_WR, {12'b0, a[3:0], hi, lo}, 1, 1'b0));
            model[int'(a)] = {hi, lo};
        end else begin
            sb.push_back(mk(K_ERR, 32'h0, 1, 1'b0));
        end
        send_byte(hi, 0);
        wait_idle();
    endtask

    task automatic do_read(input logic [7:0] a, input int dly, input bit hold, input bit junk);
        logic [15:0] v;
        withhold = hold;
        rd_delay = dly;
        send_byte(8'hBB, $urandom_range(0, 2));
        if (int'(a) < DEPTH) begin
            v = model[int'(a)];
            sb.push_back(mk(K_RD, {28'b0, a[3:0]}, 1, 1'b0));
            if (hold) begin
                sb.push_back(mk(K_ERR, 32'h0, RD_TIMEOUT, 1'b1));
            end else begin
                sb.push_back(mk(K_TX, {24'b0, v[7:0]}, -1, 1'b0));
                sb.push_back(mk(K_TX, {24'b0, v[15:8]}, -1, 1'b0));
            end
            if (junk) begin
                send_byte(a, 2);
                send_byte(8'($urandom), 0);
            end else begin
                send_byte(a, 0);
            end
        end else begin
            sb.push_back(mk(K_ERR, 32'h0, 1, 1'b0));
            send_byte(a, 0);
        end
        wait_idle();
        withhold = 1'b0;
    endtask

    task automatic bad_cmd(input logic [7:0] b);
        sb.push_back(mk(K_ERR, 32'h0, 1, 1'b0));
        send_byte(b, 0);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, b;
        int         op;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0;
        RST = 1'b1; RX_P_DATA = 8'h0; RX_D_VLD = 1'b0;
        RdData = '0; RdData_Valid = 1'b0; TX_Busy = 1'b0;
        @(posedge CLK); #1;
        do_reset();

        do_write(8'h00, 8'h02, 8'h00, 0);
        do_write(8'h01, 8'h04, 8'h00, 1);
        do_read(8'h01, 2, 1'b0, 1'b0);
        do_write(8'h08, 8'h06, 8'h00, 0);
        do_read(8'h08, 2, 1'b0, 1'b0);
        bad_cmd(8'h55);
        do_read(8'h00, 2, 1'b0, 1'b0);
        do_read(8'h02, 2, 1'b1, 1'b0);
        do_write(8'h13, 8'h77, 8'h66, 0);
        do_write(8'h07, 8'hCD, 8'hAB, 2);
        do_read(8'h07, RD_TIMEOUT - 1, 1'b0, 1'b1);

        // Reset mid-write, then the frame must restart cleanly.
        send_byte(8'hAA, 0);
        send_byte(8'h03, 0);
        send_byte(8'hFF, 0);
        do_reset();
        do_write(8'h03, 8'h11, 8'h22, 0);
        do_read(8'h03, 1, 1'b0, 1'b0);

        // Reset while waiting for read data.
        withhold = 1'b1;
        send_byte(8'hBB, 0);
        sb.push_back(mk(K_RD, 32'h1, 1, 1'b0));
        send_byte(8'h01, 3);
        do_reset();
        withhold = 1'b0;
        do_read(8'h01, 3, 1'b0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255))
                                             : 8'($urandom_range(0, DEPTH - 1));
            if (op <= 3) begin
                do_write(a, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
            end else if (op <= 7) begin
                do_read(a, $urandom_range(1, RD_TIMEOUT - 1), 1'b0, 1'($urandom_range(0, 1)));
            end else if (op == 8) begin
                b = 8'($urandom);
                while (b == 8'hAA || b == 8'hBB) b = 8'($urandom);
                bad_cmd(b);
            end else begin
                do_read(8'($urandom_range(0, DEPTH - 1)), 1, 1'b1, 1'b0);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        end

        repeat (20) @(posedge CLK);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending events, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
